// File: rtl/seq_datapath_if.sv
// Instruction handshake bundle between the fetch side (master) and the
// execution core (slave).
interface seq_datapath_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        opcode;
    logic [IDX_W-1:0]  rd;
    logic [IDX_W-1:0]  rs;
    logic [DATA_W-1:0] imm;

    modport master (output instr_valid, opcode, rd, rs, imm, input instr_ready);
    modport slave  (input instr_valid, opcode, rd, rs, imm, output instr_ready);
endinterface

// File: rtl/seq_datapath.sv
// Register-transfer execution core: register file, Z accumulator, add/sub unit
// and the IDLE/T0/T1/T2 step sequencer that drives them.
module seq_datapath #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 4
) (
    input  logic              clock,
    input  logic              clear,
    seq_datapath_if.slave     bus,
    output logic              done,
    output logic              err,
    output logic              carry,
    output logic [DATA_W-1:0] z_value,
    input  logic [IDX_W-1:0]  rd_sel,
    output logic [DATA_W-1:0] rd_data
);
    localparam logic [1:0] OP_LDI  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_MV   = 2'b10;
    localparam logic [IDX_W:0] NREGS = (IDX_W+1)'(NUM_REGS);

    typedef enum logic [1:0] {S_IDLE, S_T0, S_T1, S_T2} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_op;
    logic [IDX_W-1:0]  r_rd, r_rs;
    logic [DATA_W-1:0] r_imm, r_z;
    logic              r_carry, r_err;
    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              w_accept, w_in_bad, w_wr, w_cout;
    logic [DATA_W-1:0] w_src, w_alu, w_wdata;
    logic [DATA_W:0]   w_sum, w_diff;

    assign w_accept = (r_state == S_IDLE) && bus.instr_valid;
    assign w_in_bad = ({1'b0, bus.rd} >= NREGS) ||
                      ((bus.opcode != OP_LDI) && ({1'b0, bus.rs} >= NREGS));

    always_ff @(posedge clock) begin
        if (!clear) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        done            = 1'b0;
        bus.instr_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) w_next = (bus.opcode == OP_LDI) ? S_T0 : S_T1;
            end
            S_T0: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_T1: w_next = S_T2;
            S_T2: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Out-of-range indices simply never match, so reads give 0 and writes vanish.
    always_comb begin
        w_src   = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_rs == IDX_W'(i))   w_src   = r_regs[i];
            if (rd_sel == IDX_W'(i)) rd_data = r_regs[i];
        end
    end

    assign w_sum  = {1'b0, w_src} + {1'b0, r_imm};
    assign w_diff = {1'b0, w_src} - {1'b0, r_imm};
    assign w_cout = (r_op == OP_ADDI) ? w_sum[DATA_W] : w_diff[DATA_W];

    always_comb begin
        case (r_op)
            OP_ADDI: w_alu = w_sum[DATA_W-1:0];
            OP_MV:   w_alu = w_src;
            default: w_alu = w_diff[DATA_W-1:0];
        endcase
    end

    assign w_wr    = (r_state == S_T0) || (r_state == S_T2);
    assign w_wdata = (r_state == S_T0) ? r_imm : r_z;

    always_ff @(posedge clock) begin
        if (!clear) begin
            r_op    <= OP_LDI;
            r_rd    <= '0;
            r_rs    <= '0;
            r_imm   <= '0;
            r_z     <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op  <= bus.opcode;
                r_rd  <= bus.rd;
                r_rs  <= bus.rs;
                r_imm <= bus.imm;
                if (w_in_bad) r_err <= 1'b1;
            end
            if (r_state == S_T1) begin
                r_z <= w_alu;
                if (r_op != OP_MV) r_carry <= w_cout;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!clear)                           r_regs[i] <= '0;
            else if (w_wr && r_rd == IDX_W'(i))   r_regs[i] <= w_wdata;
        end
    end

    assign err     = r_err;
    assign carry   = r_carry;
    assign z_value = r_z;
endmodule

// File: doc/seq_datapath.md
# seq_datapath

Parametrised register-transfer datapath with built-in step sequencer. It holds a register file of NUM_REGS entries, a Z accumulator, and a one-step adder/subtractor. It also contains the T0/T1/T2 control FSM that was previously driven by hand from a bench. Instructions enter through a valid/ready handshake. The block generates the internal Rin/Rout/Zin/Zout strobes itself. It is the execution core under the upcoming instruction-fetch unit.

## Interface
Parameters:
- DATA_W, 8, width of registers, Z, and immediates
- NUM_REGS, 4, register file depth (2..16)
- IDX_W, 4, register index width (must satisfy 2^IDX_W >= NUM_REGS)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- opcode  in  2  00 LDI, 01 ADDI, 10 MV, 11 SUBI
- rd  in  IDX_W  destination register index
- rs  in  IDX_W  source register index (ignored for LDI)
- imm  in  DATA_W  immediate (ignored for MV)
- done  out  1  one-cycle pulse in final step of an instruction
- err  out  1  sticky: an out-of-range index was accepted
- carry  out  1  carry (ADDI) or borrow (SUBI) of the last ALU op
- z_value  out  DATA_W  current Z contents
- rd_sel  in  IDX_W  debug read select
- rd_data  out  DATA_W  combinational R[rd_sel]; 0 if rd_sel >= NUM_REGS

## Operation
- FSM states: IDLE, T0, T1, T2.
- IDLE:
  - instr_ready=1.
  - Accept on instr_valid && instr_ready; latch opcode, rd, rs, imm.
  - Next state is T0 for LDI, T1 otherwise.
- T0 (LDI): R[rd] <= imm; done=1; next state IDLE.
- T1:
  - ADDI: Z <= R[rs] + imm; carry <= bit DATA_W of the sum.
  - SUBI: Z <= R[rs] - imm; carry <= 1 when R[rs] < imm (borrow).
  - MV: Z <= R[rs]; carry unchanged.
  - Next state T2.
- T2: R[rd] <= Z; done=1; next state IDLE.
- Arithmetic is modulo 2^DATA_W, unsigned.
- rd == rs is legal: the read happens in T1 and the write in T2, so the old value is used.
- Out-of-range index:
  - Applies to rd (any opcode) or rs (non-LDI) with value >= NUM_REGS.
  - The instruction is still accepted and sequenced.
  - A source read returns 0.
  - The register write is suppressed; Z and carry still update.
  - err is set and stays high until reset.
- instr_ready=0 in T0/T1/T2; instr_valid is ignored there and inputs may change freely.

## Timing
- Reset (clear low at a rising edge):
  - All R[i]=0, Z=0, carry=0, err=0, done=0, state IDLE.
  - instr_ready=1 in the first cycle after clear returns high.
- Reset mid-instruction aborts it: no register write, no done.
- Reset has priority over every other event in the same cycle.
- Latency, accept edge = edge 0:
  - LDI: write at edge 1. Result visible on rd_data after edge 1. done high between edges 0 and 1.
  - ADDI/SUBI/MV: Z and carry at edge 1, register write at edge 2. done high between edges 1 and 2.
- Throughput:
  - LDI: one instruction per 2 cycles.
  - ALU/MV: one instruction per 3 cycles.
  - No back-to-back acceptance. The block re-enters IDLE and then accepts on the next edge.
- done is a single-cycle pulse, asserted combinationally from state T0 or T2.
- z_value holds until the next T1.

## Test plan
- Reset: hold clear=0 for 2 cycles with instr_valid=1 -> all rd_data=0, z_value=0, carry=0, err=0, done=0, no accept; instr_ready=1 after release.
- Original sequence, DATA_W=8:
  - LDI R0,5 -> R0=5 after 2 cycles.
  - ADDI R1,R0,5 -> Z=10 after T1; R1=10 after T2; done pulses once per instruction; carry=0.
- Wrap and borrow:
  - LDI R2,0xFE, then ADDI R3,R2,0x03 -> R3=0x01, carry=1.
  - SUBI R3,R3,0x02 -> R3=0xFF, carry=1.
  - MV R0,R3 -> R0=0xFF, carry stays 1.
- Handshake: instr_valid held high for 10 cycles with alternating opcodes -> accepts only in IDLE cycles; instr_ready low in every T0/T1/T2; no instruction dropped or duplicated.
- Abort and range:
  - Assert clear in T1 of ADDI R1,R0,1 -> R1 unchanged, no done.
  - With NUM_REGS=4, LDI R7,9 -> err=1, no register changes, rd_data(7)=0.
- Parameter sweep: DATA_W=16, NUM_REGS=16; LDI R15,0xFFFF, then ADDI R15,R15,1 -> R15=0x0000, carry=1.
